// File: rtl/chamber_timer_pkg.sv
// Shared encodings and default timings for the airlock chamber timer.
// The interlock bench imports these so both sides agree on the job durations.
package chamber_timer_pkg;

  typedef enum logic [1:0] {
    JOB_NONE  = 2'b00,
    JOB_WAIT  = 2'b01,
    JOB_DRAIN = 2'b10,
    JOB_FILL  = 2'b11
  } job_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  localparam int DEF_CLK_DIV   = 50_000_000;
  localparam int DEF_WAIT_MIN  = 5;
  localparam int DEF_DRAIN_MIN = 8;
  localparam int DEF_FILL_MIN  = 7;

  // Finished vector ordered {wait, drain, fill}; at most one bit is ever set.
  function automatic logic [2:0] finished_onehot(input job_e j);
    logic [2:0] f;
    case (j)
      JOB_WAIT:  f = 3'b100;
      JOB_DRAIN: f = 3'b010;
      JOB_FILL:  f = 3'b001;
      default:   f = 3'b000;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/chamber_timer_minute_prescaler.sv
// Divides clk down to a one-cycle "minute" tick; the count is held at zero
// while clear is high so every job starts on a fresh minute boundary.
module minute_prescaler
  import chamber_timer_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic             tick_r;

  // Next prescaler count: clear wins, otherwise wrap at CLK_DIV-1.
  always_comb begin
    count_next_s = count_r;
    if (clear) begin
      count_next_s = {CNT_W{1'b0}};
    end else if (enable) begin
      if (count_r == LAST) begin
        count_next_s = {CNT_W{1'b0}};
      end else begin
        count_next_s = count_r + CNT_W'(1);
      end
    end else begin
      count_next_s = count_r;
    end
  end

  // Count register; tick is registered so it is high exactly while count == CLK_DIV-1.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_r <= {CNT_W{1'b0}};
      tick_r  <= 1'b0;
    end else begin
      count_r <= count_next_s;
      tick_r  <= enable && !clear && (count_next_s == LAST);
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/chamber_timer.sv
// Single-job chamber timer: accepts one level request at a time, counts whole
// minutes down and holds the matching finished flag until the request drops.
module chamber_timer
  import chamber_timer_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int WAIT_MIN  = DEF_WAIT_MIN,
  parameter int DRAIN_MIN = DEF_DRAIN_MIN,
  parameter int FILL_MIN  = DEF_FILL_MIN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       waiting,
  input  logic       draining,
  input  logic       filling,
  output logic       waitFinished,
  output logic       drainFinished,
  output logic       fillFinished,
  output logic [1:0] job,
  output logic [3:0] minutesLeft
);

  state_e     state_r;
  job_e       job_r;
  logic [3:0] min_r;
  logic [2:0] fin_r;

  job_e       sel_job_s;
  logic       hold_req_s;
  logic       tick_s;
  logic       pre_clear_s;
  logic       pre_en_s;

  function automatic logic [3:0] job_minutes(input job_e j);
    logic [3:0] m;
    case (j)
      JOB_WAIT:  m = 4'(WAIT_MIN);
      JOB_DRAIN: m = 4'(DRAIN_MIN);
      JOB_FILL:  m = 4'(FILL_MIN);
      default:   m = 4'd0;
    endcase
    return m;
  endfunction

  // Fixed-priority pick among simultaneous requests: wait > drain > fill.
  always_comb begin
    sel_job_s = JOB_NONE;
    if (waiting) begin
      sel_job_s = JOB_WAIT;
    end else if (draining) begin
      sel_job_s = JOB_DRAIN;
    end else if (filling) begin
      sel_job_s = JOB_FILL;
    end else begin
      sel_job_s = JOB_NONE;
    end
  end

  // Level of the request belonging to the latched job; others are ignored.
  always_comb begin
    hold_req_s = 1'b0;
    case (job_r)
      JOB_WAIT:  hold_req_s = waiting;
      JOB_DRAIN: hold_req_s = draining;
      JOB_FILL:  hold_req_s = filling;
      default:   hold_req_s = 1'b0;
    endcase
  end

  // The prescaler only runs in RUN, so entering RUN always starts from count 0.
  assign pre_clear_s = (state_r != S_RUN);
  assign pre_en_s    = (state_r == S_RUN);

  minute_prescaler #(
    .CLK_DIV(CLK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (pre_clear_s),
    .enable(pre_en_s),
    .tick  (tick_s)
  );

  // Job FSM with registered job, minutes and finished outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= S_IDLE;
      job_r   <= JOB_NONE;
      min_r   <= 4'd0;
      fin_r   <= 3'b000;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (sel_job_s != JOB_NONE) begin
            state_r <= S_RUN;
            job_r   <= sel_job_s;
            min_r   <= job_minutes(sel_job_s);
            fin_r   <= 3'b000;
          end else begin
            state_r <= S_IDLE;
            job_r   <= JOB_NONE;
            min_r   <= 4'd0;
            fin_r   <= 3'b000;
          end
        end
        S_RUN: begin
          if (!hold_req_s) begin
            state_r <= S_IDLE;
            job_r   <= JOB_NONE;
            min_r   <= 4'd0;
            fin_r   <= 3'b000;
          end else if (tick_s) begin
            // The last minute expiring lands in DONE on the same edge; never wraps below 0.
            if (min_r <= 4'd1) begin
              state_r <= S_DONE;
              min_r   <= 4'd0;
              fin_r   <= finished_onehot(job_r);
            end else begin
              state_r <= S_RUN;
              min_r   <= min_r - 4'd1;
              fin_r   <= 3'b000;
            end
          end else begin
            state_r <= S_RUN;
            min_r   <= min_r;
            fin_r   <= 3'b000;
          end
        end
        S_DONE: begin
          if (!hold_req_s) begin
            state_r <= S_IDLE;
            job_r   <= JOB_NONE;
            min_r   <= 4'd0;
            fin_r   <= 3'b000;
          end else begin
            state_r <= S_DONE;
            min_r   <= 4'd0;
            fin_r   <= finished_onehot(job_r);
          end
        end
        default: begin
          state_r <= S_IDLE;
          job_r   <= JOB_NONE;
          min_r   <= 4'd0;
          fin_r   <= 3'b000;
        end
      endcase
    end
  end

  assign waitFinished  = fin_r[2];
  assign drainFinished = fin_r[1];
  assign fillFinished  = fin_r[0];
  assign job           = job_r;
  assign minutesLeft   = min_r;

endmodule

// File: tb/tb_chamber_timer.sv
// Directed bench for chamber_timer with a fast prescaler (CLK_DIV=4):
// a vector table of {inputs, cycles to advance, expected outputs} plus a DONE-hold sequence.
module tb_chamber_timer;

  localparam int CLK_DIV   = 4;
  localparam int WAIT_MIN  = 5;
  localparam int DRAIN_MIN = 8;
  localparam int FILL_MIN  = 7;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       waiting = 1'b0;
  logic       draining = 1'b0;
  logic       filling = 1'b0;
  logic       waitFinished;
  logic       drainFinished;
  logic       fillFinished;
  logic [1:0] job;
  logic [3:0] minutesLeft;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       rst;
    logic       w;
    logic       d;
    logic       f;
    int         n;
    logic [2:0] fin;
    logic [1:0] job;
    logic [3:0] mins;
  } vec_t;

  vec_t vecs[$];

  chamber_timer #(
    .CLK_DIV  (CLK_DIV),
    .WAIT_MIN (WAIT_MIN),
    .DRAIN_MIN(DRAIN_MIN),
    .FILL_MIN (FILL_MIN)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .waiting      (waiting),
    .draining     (draining),
    .filling      (filling),
    .waitFinished (waitFinished),
    .drainFinished(drainFinished),
    .fillFinished (fillFinished),
    .job          (job),
    .minutesLeft  (minutesLeft)
  );

  always #5 clk = ~clk;

  task automatic add(input logic rst, input logic w, input logic d, input logic f,
                     input int n, input logic [2:0] fin, input logic [1:0] j,
                     input logic [3:0] m);
    vec_t v;
    v.rst = rst; v.w = w; v.d = d; v.f = f; v.n = n;
    v.fin = fin; v.job = j; v.mins = m;
    vecs.push_back(v);
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [2:0] fin, input logic [1:0] j,
                       input logic [3:0] m);
    n_cmp++;
    if ({waitFinished, drainFinished, fillFinished, job, minutesLeft} !== {fin, j, m}) begin
      n_bad++;
      $display("FAIL %s @%0t: got fin(w,d,f)=%b%b%b job=%b min=%0d, want fin=%b job=%b min=%0d",
               nm, $time, waitFinished, drainFinished, fillFinished, job, minutesLeft,
               fin, j, m);
    end
  endtask

  initial begin
    // fill job, held past completion then dropped
    add(1'b1, 1'b0, 1'b0, 1'b0,  1, 3'b000, 2'b00, 4'd0);
    add(1'b1, 1'b0, 1'b0, 1'b1,  1, 3'b000, 2'b11, 4'd7);
    add(1'b1, 1'b0, 1'b0, 1'b1,  3, 3'b000, 2'b11, 4'd7);
    add(1'b1, 1'b0, 1'b0, 1'b1,  1, 3'b000, 2'b11, 4'd6);
    add(1'b1, 1'b0, 1'b0, 1'b1, 23, 3'b000, 2'b11, 4'd1);
    add(1'b1, 1'b0, 1'b0, 1'b1,  1, 3'b001, 2'b11, 4'd0);
    add(1'b1, 1'b0, 1'b0, 1'b1,  6, 3'b001, 2'b11, 4'd0);
    add(1'b1, 1'b0, 1'b0, 1'b0,  1, 3'b000, 2'b00, 4'd0);
    add(1'b1, 1'b0, 1'b0, 1'b0,  1, 3'b000, 2'b00, 4'd0);
    // simultaneous wait + drain: wait wins, drain follows after one idle cycle
    add(1'b1, 1'b1, 1'b1, 1'b0,  1, 3'b000, 2'b01, 4'd5);
    add(1'b1, 1'b1, 1'b1, 1'b0, 19, 3'b000, 2'b01, 4'd1);
    add(1'b1, 1'b1, 1'b1, 1'b0,  1, 3'b100, 2'b01, 4'd0);
    add(1'b1, 1'b1, 1'b1, 1'b0,  3, 3'b100, 2'b01, 4'd0);
    add(1'b1, 1'b0, 1'b1, 1'b0,  1, 3'b000, 2'b00, 4'd0);
    add(1'b1, 1'b0, 1'b1, 1'b0,  1, 3'b000, 2'b10, 4'd8);
    // drain aborted at minutesLeft=6
    add(1'b1, 1'b0, 1'b1, 1'b0,  9, 3'b000, 2'b10, 4'd6);
    add(1'b1, 1'b0, 1'b0, 1'b0,  1, 3'b000, 2'b00, 4'd0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 40, 3'b000, 2'b00, 4'd0);
    // fill raised during a running wait is ignored until wait drops
    add(1'b1, 1'b1, 1'b0, 1'b0,  1, 3'b000, 2'b01, 4'd5);
    add(1'b1, 1'b1, 1'b0, 1'b1,  8, 3'b000, 2'b01, 4'd3);
    add(1'b1, 1'b1, 1'b0, 1'b1, 12, 3'b100, 2'b01, 4'd0);
    add(1'b1, 1'b1, 1'b0, 1'b1,  2, 3'b100, 2'b01, 4'd0);
    add(1'b1, 1'b0, 1'b0, 1'b1,  1, 3'b000, 2'b00, 4'd0);
    add(1'b1, 1'b0, 1'b0, 1'b1,  1, 3'b000, 2'b11, 4'd7);
    // reset mid-fill at minutesLeft=3, then restart from 7 and complete
    add(1'b1, 1'b0, 1'b0, 1'b1, 16, 3'b000, 2'b11, 4'd3);
    add(1'b0, 1'b0, 1'b0, 1'b1,  1, 3'b000, 2'b00, 4'd0);
    add(1'b1, 1'b0, 1'b0, 1'b1,  1, 3'b000, 2'b11, 4'd7);
    add(1'b1, 1'b0, 1'b0, 1'b1, 28, 3'b001, 2'b11, 4'd0);
    add(1'b1, 1'b0, 1'b0, 1'b0,  1, 3'b000, 2'b00, 4'd0);
    // drain run to completion ahead of the hold sequence
    add(1'b1, 1'b0, 1'b1, 1'b0,  1, 3'b000, 2'b10, 4'd8);
    add(1'b1, 1'b0, 1'b1, 1'b0, 32, 3'b010, 2'b10, 4'd0);

    reset = 1'b0;
    adv(2);
    check("reset", 3'b000, 2'b00, 4'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      reset    = vecs[i].rst;
      waiting  = vecs[i].w;
      draining = vecs[i].d;
      filling  = vecs[i].f;
      adv(vecs[i].n);
      check($sformatf("vec%0d", i), vecs[i].fin, vecs[i].job, vecs[i].mins);
    end

    // DONE hold: drainFinished must stay up for 100 cycles with no re-trigger
    for (int k = 0; k < 100; k++) begin
      adv(1);
      check($sformatf("done_hold%0d", k), 3'b010, 2'b10, 4'd0);
    end
    draining = 1'b0;
    adv(1);
    check("done_release", 3'b000, 2'b00, 4'd0);
    adv(1);
    check("idle_after", 3'b000, 2'b00, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
